// File: rtl/ivl_uvm_ovl_window_stim.sv
// ivl_uvm_ovl_window_stim: programmable start/test/end window generator
// that drives an ovl_window checker, with optional single-cycle fault.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_go                  request one window (sampled only in IDLE)
//   i_win_len             number of OPEN cycles
//   i_drop_en, i_drop_at  fault enable and OPEN-cycle index of the fault
//   i_x_mode              fault drives X instead of 0 (macro builds only)
//   o_start_event, o_test_expr, o_end_event   to the checker
//   o_busy                START through GAP
//   o_done                one-cycle pulse in GAP
//   o_win_count           completed windows, saturating
//
// Build option: define OVL_WINDOW_STIM_XINJECT_EN to add i_x_mode.
module ivl_uvm_ovl_window_stim #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic [LEN_W-1:0] i_win_len,
    input  logic             i_drop_en,
    input  logic [LEN_W-1:0] i_drop_at,
`ifdef OVL_WINDOW_STIM_XINJECT_EN
    input  logic             i_x_mode,
`endif
    output logic             o_start_event,
    output logic             o_test_expr,
    output logic             o_end_event,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_win_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_OPEN,
        S_END,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] r_len;
    logic             r_drop_en;
    logic [LEN_W-1:0] r_drop_at;
    logic             w_drop_val;

    logic             w_start;
    logic             w_test;
    logic             w_end;
    logic             w_busy;
    logic             w_done;

`ifdef OVL_WINDOW_STIM_XINJECT_EN
    logic             r_x_mode;
    assign w_drop_val = r_x_mode ? 1'bx : 1'b0;
`else
    assign w_drop_val = 1'b0;
`endif

    // Next state and the OPEN-cycle index that goes with it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (i_go) w_state_nxt = S_START;
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (r_len != '0) ? S_OPEN : S_END;
            end
            S_OPEN: begin
                w_cnt_nxt = r_cnt + LEN_W'(1);
                if (r_cnt == r_len - LEN_W'(1)) w_state_nxt = S_END;
            end
            S_END:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be
    // registered and still line up with the state they belong to.
    always_comb begin
        w_start = (w_state_nxt == S_START);
        w_end   = (w_state_nxt == S_END);
        w_done  = (w_state_nxt == S_GAP);
        w_busy  = (w_state_nxt != S_IDLE);
        w_test  = 1'b0;
        unique case (w_state_nxt)
            S_START, S_END: w_test = 1'b1;
            S_OPEN: begin
                if (r_drop_en && (w_cnt_nxt == r_drop_at))
                    w_test = w_drop_val;
                else
                    w_test = 1'b1;
            end
            default: w_test = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_len         <= '0;
            r_drop_en     <= 1'b0;
            r_drop_at     <= '0;
`ifdef OVL_WINDOW_STIM_XINJECT_EN
            r_x_mode      <= 1'b0;
`endif
            o_start_event <= 1'b0;
            o_test_expr   <= 1'b0;
            o_end_event   <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_win_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            o_start_event <= w_start;
            o_test_expr   <= w_test;
            o_end_event   <= w_end;
            o_busy        <= w_busy;
            o_done        <= w_done;
            if (r_state == S_IDLE && i_go) begin
                r_len     <= i_win_len;
                r_drop_en <= i_drop_en;
                r_drop_at <= i_drop_at;
`ifdef OVL_WINDOW_STIM_XINJECT_EN
                r_x_mode  <= i_x_mode;
`endif
            end
            // Count lands as the window leaves GAP.
            if (r_state == S_GAP && o_win_count != '1)
                o_win_count <= o_win_count + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_ivl_uvm_ovl_window_stim.sv
// Self-checking bench for ivl_uvm_ovl_window_stim: directed windows
// followed by randomized traffic against a phase-based reference model.
module tb_ivl_uvm_ovl_window_stim;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [7:0] win_len;
    logic       drop_en;
    logic [7:0] drop_at;
`ifdef OVL_WINDOW_STIM_XINJECT_EN
    logic       x_mode;
`endif
    logic       start_event;
    logic       test_expr;
    logic       end_event;
    logic       busy;
    logic       done;
    logic [7:0] win_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a window is a run of phases 0..len+2 after the go edge.
    bit m_act = 0;
    int m_ph  = 0;
    int m_len = 0;
    bit m_den = 0;
    int m_dat = 0;
    bit m_xm  = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    ivl_uvm_ovl_window_stim #(.LEN_W(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_go          (go),
        .i_win_len     (win_len),
        .i_drop_en     (drop_en),
        .i_drop_at     (drop_at),
`ifdef OVL_WINDOW_STIM_XINJECT_EN
        .i_x_mode      (x_mode),
`endif
        .o_start_event (start_event),
        .o_test_expr   (test_expr),
        .o_end_event   (end_event),
        .o_busy        (busy),
        .o_done        (done),
        .o_win_count   (win_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_act = 0;
            m_cnt = 0;
        end else if (m_act) begin
            m_ph++;
            if (m_ph > m_len + 2) begin
                m_act = 0;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (go) begin
            m_act = 1;
            m_ph  = 0;
            m_len = int'(win_len);
            m_den = drop_en;
            m_dat = int'(drop_at);
`ifdef OVL_WINDOW_STIM_XINJECT_EN
            m_xm  = x_mode;
`else
            m_xm  = 0;
`endif
        end
    endtask

    task automatic compare();
        logic e_s, e_t, e_e, e_b, e_d;
        e_s = 0; e_t = 0; e_e = 0; e_b = 0; e_d = 0;
        if (m_act) begin
            e_b = 1;
            e_s = (m_ph == 0);
            e_e = (m_ph == m_len + 1);
            e_d = (m_ph == m_len + 2);
            e_t = (m_ph <= m_len + 1);
            if (m_den && m_ph >= 1 && m_ph <= m_len && m_ph - 1 == m_dat)
                e_t = m_xm ? 1'bx : 1'b0;
        end
        check("start_event", {31'd0, start_event}, {31'd0, e_s});
        check("test_expr",   {31'd0, test_expr},   {31'd0, e_t});
        check("end_event",   {31'd0, end_event},   {31'd0, e_e});
        check("busy",        {31'd0, busy},        {31'd0, e_b});
        check("done",        {31'd0, done},        {31'd0, e_d});
        check("win_count",   {24'd0, win_count},   32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic window(input int len, input bit den, input int dat,
                          input int tail);
        win_len = 8'(len);
        drop_en = den;
        drop_at = 8'(dat);
        go      = 1;
        step();
        go      = 0;
        win_len = 8'($urandom);
        drop_en = 1'($urandom);
        drop_at = 8'($urandom);
        run(tail);
    endtask

    initial begin
        int base;
        int drops;
        rst = 1; go = 0; win_len = 0; drop_en = 0; drop_at = 0;
`ifdef OVL_WINDOW_STIM_XINJECT_EN
        x_mode = 0;
`endif
        run(3);
        rst = 0;
        run(2);

        // Clean window.
        base = m_cnt;
        window(4, 0, 0, 9);
        check("clean_count", {24'd0, win_count}, 32'(base + 1));

        // Fault at the 3rd OPEN cycle; count the zero cycles seen.
        drops = 0;
        win_len = 5; drop_en = 1; drop_at = 2; go = 1;
        step();
        go = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy === 1'b1 && test_expr === 1'b0 && !done) drops++;
        end
        check("fault_drops", 32'(drops), 32'd1);

        // Edge lengths.
        window(0, 0, 0, 5);
        window(3, 1, 7, 7);

        // go held high: back-to-back windows, extra go ignored.
        base = m_cnt;
        win_len = 2; drop_en = 0; go = 1;
        run(20);
        go = 0;
        check("b2b_count", {24'd0, win_count}, 32'(base + 3));
        run(4);

        // Reset during the 2nd OPEN cycle of a len-6 window.
        window(6, 0, 0, 2);
        rst = 1;
        step();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_count", {24'd0, win_count}, 32'd0);
        rst = 0;
        run(2);
        window(6, 1, 4, 11);

`ifdef OVL_WINDOW_STIM_XINJECT_EN
        x_mode = 1;
        window(3, 1, 1, 7);
        x_mode = 0;
`endif

        // Randomized traffic with inputs changing every cycle.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            go      = ($urandom_range(0, 2) == 0);
            win_len = 8'($urandom_range(0, 9));
            drop_en = 1'($urandom);
            drop_at = 8'($urandom_range(0, 10));
`ifdef OVL_WINDOW_STIM_XINJECT_EN
            x_mode  = 1'($urandom);
`endif
            step();
        end
        rst = 0; go = 0;
        run(15);

        // Saturation of the window counter.
        win_len = 0; drop_en = 0; go = 1;
        run(1100);
        go = 0;
        run(5);
        check("sat_count", {24'd0, win_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
